// File: rtl/cp0_exc_seq_pkg.sv
// Shared definitions for the CP0 exception sequencer: register selects,
// sequencer state encoding and the default handler vector.
package cp0_exc_seq_pkg;

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;

  // Handler entry PC[31:2]; byte address 0x4180.
  localparam logic [29:0] DEFAULT_VECTOR = 30'h0000_1060;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_VEC  = 2'd2,
    ST_RET  = 2'd3
  } state_t;

endpackage

// File: rtl/cp0_exc_seq.sv
// Sequences interrupt entry and ERET at instruction boundaries, driving the
// CP0 write/EXL controls and redirecting/stalling fetch while a sequence runs.
module cp0_exc_seq
  import cp0_exc_seq_pkg::*;
#(
  parameter logic [29:0] VECTOR = DEFAULT_VECTOR,
  parameter int          CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_done,
  input  logic [29:0]      pc_next,
  input  logic             is_eret,
  input  logic             mtc0_req,
  input  logic [4:0]       mtc0_sel,
  input  logic [31:0]      mtc0_data,
  input  logic             int_req,
  input  logic [29:0]      epc,
  output logic             cp0_wen,
  output logic [4:0]       cp0_sel,
  output logic [31:0]      cp0_din,
  output logic [29:0]      cp0_pc,
  output logic             exl_set,
  output logic             exl_clr,
  output logic             pc_redirect,
  output logic [29:0]      pc_target,
  output logic             stall,
  output logic [CNT_W-1:0] int_count
);

  state_t      state;
  state_t      state_next;
  logic [29:0] save_pc;
  logic        int_accept;

  // ERET outranks the interrupt; the interrupt is simply re-sampled later.
  assign int_accept = (state == ST_IDLE) && instr_done && !is_eret && int_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      save_pc   <= '0;
      int_count <= '0;
    end else begin
      state <= state_next;
      if (int_accept) begin
        save_pc <= pc_next;
      end
      if ((state == ST_SAVE) && (int_count != {CNT_W{1'b1}})) begin
        int_count <= int_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    cp0_wen     = 1'b0;
    cp0_sel     = '0;
    cp0_din     = '0;
    cp0_pc      = '0;
    exl_set     = 1'b0;
    exl_clr     = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    stall       = 1'b0;

    case (state)
      ST_IDLE: begin
        // Pass-through is gated by reset so nothing leaks out while it is held.
        if (rst) begin
          cp0_wen = mtc0_req & instr_done;
          cp0_sel = mtc0_sel;
          cp0_din = mtc0_data;
          cp0_pc  = mtc0_data[31:2];
        end
        if (instr_done) begin
          if (is_eret) begin
            state_next = ST_RET;
          end else if (int_req) begin
            state_next = ST_SAVE;
          end
        end
      end
      ST_SAVE: begin
        cp0_wen    = 1'b1;
        cp0_sel    = SEL_EPC;
        cp0_pc     = save_pc;
        exl_set    = 1'b1;
        stall      = 1'b1;
        state_next = ST_VEC;
      end
      ST_VEC: begin
        pc_redirect = 1'b1;
        pc_target   = VECTOR;
        stall       = 1'b1;
        state_next  = ST_IDLE;
      end
      ST_RET: begin
        exl_clr     = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = epc;
        stall       = 1'b1;
        state_next  = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Self-checking bench for cp0_exc_seq: directed scenarios with literal
// expectations, then randomized traffic against a scheduled-action model.
module tb_cp0_exc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_done;
  logic [29:0] pc_next;
  logic        is_eret;
  logic        mtc0_req;
  logic [4:0]  mtc0_sel;
  logic [31:0] mtc0_data;
  logic        int_req;
  logic [29:0] epc;

  logic        cp0_wen, exl_set, exl_clr, pc_redirect, stall;
  logic [4:0]  cp0_sel;
  logic [31:0] cp0_din;
  logic [29:0] cp0_pc, pc_target;
  logic [15:0] int_count;

  logic        s_cp0_wen, s_exl_set, s_exl_clr, s_pc_redirect, s_stall;
  logic [4:0]  s_cp0_sel;
  logic [31:0] s_cp0_din;
  logic [29:0] s_cp0_pc, s_pc_target;
  logic [1:0]  s_int_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cp0_exc_seq dut (
    .clk(clk), .rst(rst), .instr_done(instr_done), .pc_next(pc_next),
    .is_eret(is_eret), .mtc0_req(mtc0_req), .mtc0_sel(mtc0_sel),
    .mtc0_data(mtc0_data), .int_req(int_req), .epc(epc),
    .cp0_wen(cp0_wen), .cp0_sel(cp0_sel), .cp0_din(cp0_din), .cp0_pc(cp0_pc),
    .exl_set(exl_set), .exl_clr(exl_clr), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .stall(stall), .int_count(int_count)
  );

  // Narrow counter instance shares all stimulus and exercises saturation.
  cp0_exc_seq #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .instr_done(instr_done), .pc_next(pc_next),
    .is_eret(is_eret), .mtc0_req(mtc0_req), .mtc0_sel(mtc0_sel),
    .mtc0_data(mtc0_data), .int_req(int_req), .epc(epc),
    .cp0_wen(s_cp0_wen), .cp0_sel(s_cp0_sel), .cp0_din(s_cp0_din), .cp0_pc(s_cp0_pc),
    .exl_set(s_exl_set), .exl_clr(s_exl_clr), .pc_redirect(s_pc_redirect),
    .pc_target(s_pc_target), .stall(s_stall), .int_count(s_int_count)
  );

  // Model: a queue of stall-cycle actions still owed; empty means idle.
  typedef struct {
    bit        wen;
    bit [4:0]  sel;
    bit [29:0] pc;
    bit        set;
    bit        clr;
    bit        redir;
    bit [29:0] target;
    bit        live_epc;
    bit        counts;
  } act_t;

  act_t        sched[$];
  int unsigned m_count;
  int unsigned s_count;

  task automatic applyStimulus(input bit r, input bit done, input bit [29:0] pn,
                               input bit er, input bit mreq, input bit [4:0] ms,
                               input bit [31:0] md, input bit ir, input bit [29:0] e);
    rst        = r;
    instr_done = done;
    pc_next    = pn;
    is_eret    = er;
    mtc0_req   = mreq;
    mtc0_sel   = ms;
    mtc0_data  = md;
    int_req    = ir;
    epc        = e;
    if (!r) begin
      sched.delete();
      m_count = 0;
      s_count = 0;
    end
  endtask

  task automatic idleCycle(input bit [29:0] e);
    applyStimulus(1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    bit        e_wen, e_set, e_clr, e_redir, e_stall;
    bit [4:0]  e_sel;
    bit [31:0] e_din;
    bit [29:0] e_pc, e_target;
    act_t      a;
    #1;
    {e_wen, e_set, e_clr, e_redir, e_stall} = '0;
    e_sel = '0; e_din = '0; e_pc = '0; e_target = '0;
    if (rst) begin
      if (sched.size() != 0) begin
        a        = sched[0];
        e_wen    = a.wen;
        e_sel    = a.sel;
        e_pc     = a.pc;
        e_set    = a.set;
        e_clr    = a.clr;
        e_redir  = a.redir;
        e_target = a.live_epc ? epc : a.target;
        e_stall  = 1'b1;
      end else begin
        e_wen = mtc0_req & instr_done;
        e_sel = mtc0_sel;
        e_din = mtc0_data;
        e_pc  = mtc0_data[31:2];
      end
    end
    checkOutput("cp0_wen",     32'(cp0_wen),     32'(e_wen));
    checkOutput("cp0_sel",     32'(cp0_sel),     32'(e_sel));
    checkOutput("cp0_din",     cp0_din,          e_din);
    checkOutput("cp0_pc",      32'(cp0_pc),      32'(e_pc));
    checkOutput("exl_set",     32'(exl_set),     32'(e_set));
    checkOutput("exl_clr",     32'(exl_clr),     32'(e_clr));
    checkOutput("pc_redirect", 32'(pc_redirect), 32'(e_redir));
    checkOutput("pc_target",   32'(pc_target),   32'(e_target));
    checkOutput("stall",       32'(stall),       32'(e_stall));
    checkOutput("int_count",   32'(int_count),   m_count);
    checkOutput("s_stall",     32'(s_stall),     32'(e_stall));
    checkOutput("s_int_count", 32'(s_int_count), s_count);
  endtask

  task automatic advance();
    act_t a;
    @(posedge clk);
    if (rst) begin
      if (sched.size() != 0) begin
        a = sched.pop_front();
        if (a.counts) begin
          if (m_count < 65535) m_count++;
          if (s_count < 3) s_count++;
        end
      end else if (instr_done) begin
        if (is_eret) begin
          a = '{default: 0};
          a.clr = 1; a.redir = 1; a.live_epc = 1;
          sched.push_back(a);
        end else if (int_req) begin
          a = '{default: 0};
          a.wen = 1; a.sel = 5'd14; a.pc = pc_next; a.set = 1; a.counts = 1;
          sched.push_back(a);
          a = '{default: 0};
          a.redir = 1; a.target = 30'h0000_1060;
          sched.push_back(a);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b1, 30'h123, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 30'h0);
    @(negedge clk);

    // Reset held with requests active.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 30'h123, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 30'h0);
      compareModel();
      checkOutput("rst_wen", 32'(cp0_wen), 32'd0);
      checkOutput("rst_stall", 32'(stall), 32'd0);
      checkOutput("rst_redirect", 32'(pc_redirect), 32'd0);
      checkOutput("rst_count", 32'(int_count), 32'd0);
      advance();
    end
    idleCycle(30'h0);
    compareModel();
    checkOutput("post_rst_stall", 32'(stall), 32'd0);
    checkOutput("post_rst_exl_set", 32'(exl_set), 32'd0);
    advance();

    // Interrupt entry.
    applyStimulus(1'b1, 1'b1, 30'h0000_0C05, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 30'h0);
    compareModel();
    checkOutput("accept_stall", 32'(stall), 32'd0);
    advance();
    idleCycle(30'h0);
    compareModel();
    checkOutput("save_wen", 32'(cp0_wen), 32'd1);
    checkOutput("save_sel", 32'(cp0_sel), 32'd14);
    checkOutput("save_pc", 32'(cp0_pc), 32'h0000_0C05);
    checkOutput("save_exl_set", 32'(exl_set), 32'd1);
    checkOutput("save_stall", 32'(stall), 32'd1);
    advance();
    idleCycle(30'h0);
    compareModel();
    checkOutput("vec_redirect", 32'(pc_redirect), 32'd1);
    checkOutput("vec_target", 32'(pc_target), 32'h0000_1060);
    checkOutput("vec_stall", 32'(stall), 32'd1);
    advance();
    idleCycle(30'h0);
    compareModel();
    checkOutput("entry_count", 32'(int_count), 32'd1);
    checkOutput("entry_done_stall", 32'(stall), 32'd0);
    advance();

    // ERET.
    applyStimulus(1'b1, 1'b1, 30'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 30'h0000_0C05);
    compareModel();
    advance();
    idleCycle(30'h0000_0C05);
    compareModel();
    checkOutput("ret_exl_clr", 32'(exl_clr), 32'd1);
    checkOutput("ret_redirect", 32'(pc_redirect), 32'd1);
    checkOutput("ret_target", 32'(pc_target), 32'h0000_0C05);
    checkOutput("ret_stall", 32'(stall), 32'd1);
    advance();
    idleCycle(30'h0);
    compareModel();
    checkOutput("ret_done_stall", 32'(stall), 32'd0);
    advance();

    // ERET and interrupt at the same boundary: ERET wins.
    applyStimulus(1'b1, 1'b1, 30'h0777, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 30'h0AAA);
    compareModel();
    advance();
    applyStimulus(1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 30'h0AAA);
    compareModel();
    checkOutput("both_exl_set", 32'(exl_set), 32'd0);
    checkOutput("both_exl_clr", 32'(exl_clr), 32'd1);
    checkOutput("both_target", 32'(pc_target), 32'h0AAA);
    advance();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 30'h0555, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 30'h0);
      compareModel();
      checkOutput("nodone_stall", 32'(stall), 32'd0);
      advance();
    end
    idleCycle(30'h0);
    compareModel();
    checkOutput("nodone_count", 32'(int_count), 32'd1);
    advance();

    // MTC0 pass-through, alone and with an interrupt accept.
    applyStimulus(1'b1, 1'b1, 30'h0, 1'b0, 1'b1, 5'd12, 32'h0000_FC01, 1'b0, 30'h0);
    compareModel();
    checkOutput("mtc0_wen", 32'(cp0_wen), 32'd1);
    checkOutput("mtc0_sel", 32'(cp0_sel), 32'd12);
    checkOutput("mtc0_din", cp0_din, 32'h0000_FC01);
    advance();
    applyStimulus(1'b1, 1'b1, 30'h0D00, 1'b0, 1'b1, 5'd12, 32'h0000_FC01, 1'b1, 30'h0);
    compareModel();
    checkOutput("mtc0_int_wen", 32'(cp0_wen), 32'd1);
    checkOutput("mtc0_int_din", cp0_din, 32'h0000_FC01);
    advance();
    idleCycle(30'h0);
    compareModel();
    checkOutput("mtc0_save_sel", 32'(cp0_sel), 32'd14);
    checkOutput("mtc0_save_pc", 32'(cp0_pc), 32'h0D00);
    checkOutput("mtc0_save_set", 32'(exl_set), 32'd1);
    advance();
    idleCycle(30'h0);
    compareModel();
    advance();

    // Reset asserted during VEC.
    applyStimulus(1'b1, 1'b1, 30'h0123, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 30'h0);
    compareModel();
    advance();
    idleCycle(30'h0);
    compareModel();
    advance();
    idleCycle(30'h0);
    compareModel();
    checkOutput("midrst_vec_redirect", 32'(pc_redirect), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("midrst_redirect", 32'(pc_redirect), 32'd0);
    checkOutput("midrst_stall", 32'(stall), 32'd0);
    applyStimulus(1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 30'h0);
    compareModel();
    advance();
    idleCycle(30'h0);
    compareModel();
    checkOutput("midrst_after_stall", 32'(stall), 32'd0);
    checkOutput("midrst_after_count", 32'(int_count), 32'd0);
    advance();

    // Four interrupts: narrow counter saturates at 3.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 30'(i + 16), 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 30'h0);
      compareModel();
      advance();
      idleCycle(30'h0);
      compareModel();
      advance();
      idleCycle(30'h0);
      compareModel();
      advance();
    end
    idleCycle(30'h0);
    compareModel();
    checkOutput("sat_small", 32'(s_int_count), 32'd3);
    checkOutput("sat_big", 32'(int_count), 32'd4);
    advance();

    // Randomized traffic, including occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1,
                    30'($urandom), $urandom_range(0, 5) == 0,
                    $urandom_range(0, 2) == 0, 5'($urandom),
                    $urandom, $urandom_range(0, 2) == 0, 30'($urandom));
      compareModel();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_exc_seq.md
Name: cp0_exc_seq

Overview:
- Sequencer in front of the CP0 register block.
- Decides at instruction boundaries when to take a pending hardware interrupt or execute ERET.
- Drives the CP0 write/EXL controls: Wen, Sel, DIn, pc input, EXLSet, EXLClr.
- Redirects the fetch PC and stalls the pipeline while a sequence runs.
- In IDLE, passes the datapath's MTC0 writes through to CP0.

Parameters:
- VECTOR, 30'h0000_1060, handler entry PC[31:2] (byte address 0x4180).
- CNT_W, 16, width of the saturating interrupt-taken counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_done  in  1  an instruction commits this cycle (boundary).
- pc_next  in  30  PC[31:2] of the instruction following the committing one.
- is_eret  in  1  committing instruction is ERET (qualified by instr_done).
- mtc0_req  in  1  committing instruction is MTC0 (qualified by instr_done).
- mtc0_sel  in  5  MTC0 destination register number.
- mtc0_data  in  32  MTC0 write data.
- int_req  in  1  IntReq from CP0 (already masked by IM/IE/EXL).
- epc  in  30  EPC[31:2] from CP0.
- cp0_wen  out  1  CP0 write enable.
- cp0_sel  out  5  CP0 register select.
- cp0_din  out  32  CP0 write data.
- cp0_pc  out  30  CP0 pc input, which is the EPC write source.
- exl_set  out  1  CP0 EXLSet.
- exl_clr  out  1  CP0 EXLClr.
- pc_redirect  out  1  fetch loads pc_target on the next edge.
- pc_target  out  30  redirect address [31:2].
- stall  out  1  freeze fetch/commit.
- int_count  out  CNT_W  interrupts taken, saturating.

Behaviour:
- States: IDLE, SAVE, VEC, RET. State, save register (30b) and int_count are flops. All outputs decode from state, except the IDLE MTC0 pass-through.
- Reset (rst=0, async):
  - state goes to IDLE; save reg = 0; int_count = 0.
  - All outputs are 0 while reset is held and in the first IDLE cycle without requests.
  - Reset mid-sequence abandons it; no partial EXL or EPC write is re-issued.
- IDLE, at a boundary (instr_done=1), transitions are evaluated in priority order:
  1. is_eret=1 -> RET. ERET wins over int_req; the interrupt is re-sampled at a later boundary.
  2. int_req=1 -> SAVE; save reg <= pc_next.
  3. Otherwise stay in IDLE.
  - With instr_done=0, the block stays in IDLE regardless of int_req and is_eret.
- IDLE MTC0 pass-through (combinational):
  - cp0_wen = mtc0_req & instr_done; cp0_sel = mtc0_sel; cp0_din = mtc0_data.
  - cp0_pc = mtc0_data[31:2]; this lets MTC0 to Sel 14 load EPC.
  - An MTC0 committing in the same cycle as an interrupt accept still writes in that cycle; its successor PC is what gets saved.
- SAVE (1 cycle):
  - Outputs: cp0_wen=1, cp0_sel=14, cp0_pc = save reg, exl_set=1, stall=1.
  - int_count += 1; it holds at all-ones.
  - Always transitions to VEC.
- VEC (1 cycle):
  - Outputs: pc_redirect=1, pc_target = VECTOR, stall=1.
  - Always transitions to IDLE.
- RET (1 cycle):
  - Outputs: exl_clr=1, pc_redirect=1, pc_target = epc (sampled live in this cycle), stall=1.
  - Transitions to IDLE.
- Outside their states, the outputs above are 0, and cp0_sel/cp0_din/cp0_pc are 0 unless in pass-through.
- While stall=1 the datapath guarantees instr_done=0. Any instr_done, mtc0_req or is_eret seen in SAVE/VEC/RET is ignored; no write is issued.
- Latency:
  - Interrupt accept edge -> EPC/EXL written at the end of the next cycle -> redirect one cycle later. Total 2 stall cycles.
  - ERET -> 1 stall cycle.
- Never asserts exl_set and exl_clr together.
- Never drives cp0_wen with Sel 14 from SAVE in the same cycle as a pass-through.

Decomposition:
- Shared package holds:
  - CP0 select constants: SEL_SR=12, SEL_CAUSE=13, SEL_EPC=14, SEL_PRID=15.
  - The state encoding (2-bit IDLE/SAVE/VEC/RET).
  - The default handler vector constant.
- A single flat module. The saturating counter is small enough to stay inline; no sub-module.

Test Plan:
- Reset: hold rst=0 with int_req=1 and instr_done=1 -> all outputs 0 and int_count=0; after release with both low, outputs remain 0.
- Interrupt entry with int_req=1, instr_done=1, pc_next=30'h0000_0C05:
  - Next cycle: cp0_wen=1, cp0_sel=14, cp0_pc=30'h0000_0C05, exl_set=1, stall=1.
  - Following cycle: pc_redirect=1, pc_target=30'h0000_1060.
  - int_count=1.
- ERET with is_eret=1, instr_done=1, epc=30'h0000_0C05 -> next cycle exl_clr=1, pc_redirect=1, pc_target=30'h0000_0C05, stall=1; then IDLE.
- Simultaneous events:
  - is_eret=1 and int_req=1 at the same boundary -> RET taken, no exl_set, int_count unchanged.
  - int_req=1 with instr_done=0 for 5 cycles -> no action.
- MTC0 pass-through:
  - mtc0_req=1, sel=12, data=32'h0000_FC01 -> same-cycle cp0_wen=1, cp0_din=32'h0000_FC01.
  - Same plus int_req=1 -> write occurs, then SAVE on the next cycle.
- Reset mid-sequence: assert rst=0 during VEC -> pc_redirect drops immediately, state is IDLE after release; saturation check preloads with CNT_W=2 and takes 4 interrupts -> int_count=3.
